// File: rtl/multicycle_pkg.sv
// Shared types for the multi-cycle RV32I control sequencer.
// State enum, opcode values, datapath select encodings.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_JAL,
        S_JALR,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_CMP   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] RES_ALUREG = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // Unknown opcodes fall into TRAP.
    function automatic state_t decode_op(
        input logic [6:0] op
    );
        unique case (1'b1)
            op == OP_LOAD,
            op == OP_STORE:  return S_MEMADR;
            op == OP_R:      return S_EXECR;
            op == OP_I:      return S_EXECI;
            op == OP_BRANCH: return S_BRANCH;
            op == OP_JAL:    return S_JAL;
            op == OP_JALR:   return S_JALR;
            op == OP_LUI:    return S_LUI;
            default:         return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation for the multi-cycle sequencer.
// funct3 selects which ALU compare flag decides "taken".
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    // 010 and 011 are not branch encodings and never take.
    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle RV32I control sequencer with retired-instruction counter.
// Define MULTICYCLE_MEM_HS_EN to honour mem_ready wait states.
module multicycle_seq
    import multicycle_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int OP_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_WIDTH-1:0]  op,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           result_src,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] retired
);

    state_t     state;
    logic [6:0] opc;
    logic       mem_go;
    logic       taken;
    logic       retire;

    assign opc = 7'(op);

`ifdef MULTICYCLE_MEM_HS_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .taken  (taken)
    );

    // Sequencer state; memory states hold until mem_go.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH:
                    if (mem_go) state <= S_DECODE;
                S_DECODE:
                    state <= decode_op(opc);
                S_MEMADR:
                    state <= (opc == OP_LOAD) ?
                             S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:
                    if (mem_go) state <= S_MEMWB;
                S_MEMWRITE:
                    if (mem_go) state <= S_FETCH;
                S_EXECR, S_EXECI, S_JAL,
                S_JALR, S_LUI:
                    state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BRANCH:
                    state <= S_FETCH;
                default:
                    state <= S_TRAP;
            endcase
        end
    end

    // Last cycle of an instruction: next state is FETCH.
    always_comb begin
        retire = 1'b0;
        unique case (state)
            S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
            S_MEMWRITE:                 retire = mem_go;
            default:                    retire = 1'b0;
        endcase
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_WIDTH'(1);
        end
    end

    // Moore decode of datapath controls.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUREG;
        trap       = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_read   = 1'b1;
                ir_write   = mem_go;
                pc_write   = mem_go;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_JAL, S_JALR: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUREG;
                pc_write   = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUREG;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_CMP;
                result_src = RES_ALUREG;
                pc_write   = taken;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

endmodule
